// File: rtl/ham_pkg.sv
// Shared Hamming(7,4) definitions for the receive framer
// and the future encoder.
package ham_pkg;

    localparam int CW_W     = 7;
    localparam int BITCNT_W = 3;

    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(CW_W - 1);

    // Hamming position p maps to codeword bit p-1
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_D1 = 2;
    localparam int POS_P4 = 3;
    localparam int POS_D2 = 4;
    localparam int POS_D3 = 5;
    localparam int POS_D4 = 6;

    typedef enum logic {
        IDLE,
        SHIFT
    } framer_state_t;

endpackage

// File: rtl/ham_rx_framer_if.sv
// Serial input and codeword output handshake bundle
// of the Hamming receive framer.
interface ham_rx_framer_if;

    logic                     serial_in;
    logic                     serial_valid;
    logic                     sof;
    logic [ham_pkg::CW_W-1:0] message;
    logic                     msg_valid;
    logic                     msg_ready;

    modport master (
        output serial_in,
        output serial_valid,
        output sof,
        output msg_ready,
        input  message,
        input  msg_valid
    );

    modport slave (
        input  serial_in,
        input  serial_valid,
        input  sof,
        input  msg_ready,
        output message,
        output msg_valid
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter, cleared only by reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ham_rx_framer.sv
// Serial-to-parallel framer collecting one Hamming(7,4)
// codeword, LSB first, into a one-entry output register.
module ham_rx_framer
    import ham_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    ham_rx_framer_if.slave   bus,
    output logic             in_frame,
    output logic [CNT_W-1:0] abort_cnt,
    output logic [CNT_W-1:0] overrun_cnt
);

    framer_state_t       state_q;
    logic [BITCNT_W-1:0] bitcnt_q;
    logic [CW_W-1:0]     shreg_q;
    logic [CW_W-1:0]     msg_q;
    logic                msg_valid_q;

    logic            bit_ok;
    logic            abort_inc;
    logic            done;
    logic            load_ok;
    logic            overrun_inc;
    logic [CW_W-1:0] word_d;

    assign bit_ok      = bus.serial_valid && !bus.sof;
    assign abort_inc   = bus.serial_valid && bus.sof
                         && (state_q == SHIFT);
    assign done        = bit_ok && (state_q == SHIFT)
                         && (bitcnt_q == LAST_BIT);
    assign load_ok     = !msg_valid_q || bus.msg_ready;
    assign overrun_inc = done && !load_ok;
    assign word_d      = {bus.serial_in, shreg_q[CW_W-2:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
        end else begin
            // A load in the same cycle overrides this drain below
            if (msg_valid_q && bus.msg_ready) begin
                msg_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (bus.serial_valid && bus.sof) begin
                        shreg_q  <= {{(CW_W-1){1'b0}}, bus.serial_in};
                        bitcnt_q <= BITCNT_W'(1);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.serial_valid && bus.sof) begin
                        shreg_q  <= {{(CW_W-1){1'b0}}, bus.serial_in};
                        bitcnt_q <= BITCNT_W'(1);
                    end else if (bit_ok) begin
                        shreg_q[bitcnt_q] <= bus.serial_in;
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_q <= '0;
                            state_q  <= IDLE;
                            if (load_ok) begin
                                msg_q       <= word_d;
                                msg_valid_q <= 1'b1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + BITCNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.message   = msg_q;
    assign bus.msg_valid = msg_valid_q;
    assign in_frame      = (state_q == SHIFT);

    sat_counter #(.W(CNT_W)) u_abort_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (abort_inc),
        .count (abort_cnt)
    );

    sat_counter #(.W(CNT_W)) u_overrun_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (overrun_inc),
        .count (overrun_cnt)
    );

endmodule

// File: tb/tb_ham_rx_framer.sv
// Directed bench for ham_rx_framer with a queue-based
// frame model checked every cycle.
module tb_ham_rx_framer;

    localparam int CNT_W = 2;
    localparam int MAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             in_frame;
    logic [CNT_W-1:0] abort_cnt;
    logic [CNT_W-1:0] overrun_cnt;

    ham_rx_framer_if bus ();

    ham_rx_framer #(.CNT_W(CNT_W)) dut (
        .clock       (clk),
        .reset       (rst),
        .bus         (bus.slave),
        .in_frame    (in_frame),
        .abort_cnt   (abort_cnt),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_tot;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Model: a frame is the list of bits collected since sof
    bit        q[$];
    logic [6:0] m_msg;
    bit        m_vld;
    int        m_ab;
    int        m_ov;
    logic [6:0] m_w;
    bit        m_done;

    always @(posedge clk) begin
        m_done = 0;
        m_w    = '0;
        if (rst) begin
            q.delete();
            m_msg = '0;
            m_vld = 0;
            m_ab  = 0;
            m_ov  = 0;
        end else begin
            if (bus.serial_valid) begin
                if (bus.sof) begin
                    if (q.size() != 0)
                        m_ab = (m_ab >= MAX) ? MAX : m_ab + 1;
                    q.delete();
                    q.push_back(bus.serial_in);
                end else if (q.size() != 0) begin
                    q.push_back(bus.serial_in);
                    if (q.size() == 7) begin
                        for (int i = 0; i < 7; i++) m_w[i] = q[i];
                        m_done = 1;
                        q.delete();
                    end
                end
            end
            if (m_done && m_vld && !bus.msg_ready) begin
                m_ov = (m_ov >= MAX) ? MAX : m_ov + 1;
            end else if (m_done) begin
                m_msg = m_w;
                m_vld = 1;
            end else if (m_vld && bus.msg_ready) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("message", 32'(bus.message), 32'(m_msg));
        chk("msg_valid", 32'(bus.msg_valid), 32'(m_vld));
        chk("in_frame", 32'(in_frame), 32'(q.size() != 0));
        chk("abort_cnt", 32'(abort_cnt), 32'(m_ab));
        chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ov));
    end

    task automatic cyc(input logic v, input logic s,
                       input logic b, input logic r);
        bus.serial_valid = v;
        bus.sof          = s;
        bus.serial_in    = b;
        bus.msg_ready    = r;
        @(negedge clk);
    endtask

    task automatic send(input logic [6:0] w, input logic rb,
                        input logic rl, input bit gaps);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, i == 0, w[i], (i == 6) ? rl : rb);
            if (gaps && i < 6) cyc(1'b0, 1'b1, ~w[i], rb);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_msg"}, 32'(bus.message), 0);
        chk({nm, "_vld"}, 32'(bus.msg_valid), 0);
        chk({nm, "_inf"}, 32'(in_frame), 0);
        chk({nm, "_ab"}, 32'(abort_cnt), 0);
        chk({nm, "_ov"}, 32'(overrun_cnt), 0);
    endtask

    initial begin
        logic [6:0] w07;
        n_pass = 0;
        n_tot  = 0;
        w07    = 7'h07;
        rst    = 1'b1;
        bus.serial_valid = 1'b0;
        bus.sof          = 1'b0;
        bus.serial_in    = 1'b0;
        bus.msg_ready    = 1'b0;
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk_zero("reset");
        rst = 1'b0;

        // stray bits while idle
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'(i), 1'b0);
        chk_zero("stray");

        // single frame, in_frame across bits 2-7
        chk("pre_inf", 32'(in_frame), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, i == 0, w07[i], 1'b1);
            chk("single_inf", 32'(in_frame), 32'(i < 6));
        end
        chk("single_msg", 32'(bus.message), 32'h07);
        chk("single_vld", 32'(bus.msg_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_drop", 32'(bus.msg_valid), 0);
        chk("single_keep", 32'(bus.message), 32'h07);

        // backpressure and overrun
        send(7'h07, 1'b0, 1'b0, 0);
        send(7'h78, 1'b0, 1'b0, 0);
        chk("ovr_msg", 32'(bus.message), 32'h07);
        chk("ovr_cnt", 32'(overrun_cnt), 1);
        chk("ovr_vld", 32'(bus.msg_valid), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_drain", 32'(bus.msg_valid), 0);

        // simultaneous drain and load
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk_zero("rst2");
        send(7'h07, 1'b0, 1'b0, 0);
        send(7'h78, 1'b0, 1'b1, 0);
        chk("sim_msg", 32'(bus.message), 32'h78);
        chk("sim_vld", 32'(bus.msg_valid), 1);
        chk("sim_ov", 32'(overrun_cnt), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // abort with gaps
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("ab_inf", 32'(in_frame), 1);
        chk("ab_pre", 32'(abort_cnt), 0);
        send(7'h2A, 1'b1, 1'b1, 1);
        chk("ab_cnt", 32'(abort_cnt), 1);
        chk("ab_msg", 32'(bus.message), 32'h2A);
        chk("ab_vld", 32'(bus.msg_valid), 1);

        // saturation: one start plus five aborts
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sat_cnt", 32'(abort_cnt), 3);
        chk("sat_vld", 32'(bus.msg_valid), 1);
        chk("sat_inf", 32'(in_frame), 1);

        // reset mid-frame while holding a message
        rst = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        chk_zero("rst3");
        send(7'h55, 1'b1, 1'b1, 0);
        chk("post_msg", 32'(bus.message), 32'h55);
        chk("post_vld", 32'(bus.msg_valid), 1);
        chk("post_ab", 32'(abort_cnt), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
